// File: rtl/step_scheduler.sv
// Step timing and per-voice trigger issue for the beat sequencer; one step = max(step_period, MIN_PERIOD) cycles.
// Triggers are held on trig_valid until trig_ready; a step that expires with triggers still pending pulses overrun and drops them.
module step_scheduler #(
  parameter int unsigned MIN_PERIOD = 8
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        poweron,
  input  logic [15:0] row0,
  input  logic [15:0] row1,
  input  logic [15:0] row2,
  input  logic [15:0] row3,
  input  logic [15:0] row4,
  input  logic [15:0] row5,
  input  logic [15:0] row6,
  input  logic [6:0]  mute,
  input  logic [23:0] step_period,
  input  logic        trig_ready,
  output logic [3:0]  counter,
  output logic        step_tick,
  output logic        trig_valid,
  output logic [2:0]  trig_voice,
  output logic        overrun,
  output logic        running
);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_ISSUE, S_WAIT} state_t;

  state_t      state_q;
  logic [3:0]  counter_q;
  logic        step_tick_q;
  logic        trig_valid_q;
  logic [2:0]  trig_voice_q;
  logic        overrun_q;
  logic        running_q;
  logic        late_q;
  logic [23:0] period_q;
  logic [23:0] count_q;
  logic [6:0]  mask_q;

  logic [6:0]  hits;
  logic [6:0]  mask_d;
  logic [23:0] period_d;
  logic        accept;
  logic        expiry;

  function automatic logic [2:0] lowest_voice(input logic [6:0] m);
    lowest_voice = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (m[i]) lowest_voice = 3'(i);
    end
  endfunction

  // A late step has already advanced the counter, so its expiry must not fire again.
  always_comb begin
    hits = {row6[counter_q], row5[counter_q], row4[counter_q], row3[counter_q],
            row2[counter_q], row1[counter_q], row0[counter_q]} & ~mute;
    period_d = (step_period < 24'(MIN_PERIOD)) ? 24'(MIN_PERIOD) : step_period;
    accept = trig_valid_q && trig_ready;
    mask_d = mask_q;
    if (accept) mask_d[trig_voice_q] = 1'b0;
    expiry = !late_q && (count_q == period_q - 24'd1);
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q      <= S_IDLE;
      counter_q    <= 4'd0;
      step_tick_q  <= 1'b0;
      trig_valid_q <= 1'b0;
      trig_voice_q <= 3'd0;
      overrun_q    <= 1'b0;
      running_q    <= 1'b0;
      late_q       <= 1'b0;
      period_q     <= 24'(MIN_PERIOD);
      count_q      <= 24'd0;
      mask_q       <= 7'd0;
    end else if (!poweron) begin
      state_q      <= S_IDLE;
      counter_q    <= 4'd0;
      step_tick_q  <= 1'b0;
      trig_valid_q <= 1'b0;
      trig_voice_q <= 3'd0;
      overrun_q    <= 1'b0;
      running_q    <= 1'b0;
      late_q       <= 1'b0;
      count_q      <= 24'd0;
      mask_q       <= 7'd0;
    end else begin
      step_tick_q <= 1'b0;
      overrun_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          state_q     <= S_LATCH;
          step_tick_q <= 1'b1;
          running_q   <= 1'b1;
          count_q     <= 24'd0;
        end
        S_LATCH: begin
          period_q <= period_d;
          mask_q   <= hits;
          count_q  <= 24'd1;
          late_q   <= 1'b0;
          if (hits != 7'd0) begin
            state_q      <= S_ISSUE;
            trig_valid_q <= 1'b1;
            trig_voice_q <= lowest_voice(hits);
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_ISSUE: begin
          count_q <= count_q + 24'd1;
          if (late_q) begin
            if (accept) begin
              state_q      <= S_LATCH;
              step_tick_q  <= 1'b1;
              trig_valid_q <= 1'b0;
              mask_q       <= 7'd0;
              count_q      <= 24'd0;
              late_q       <= 1'b0;
            end
          end else if (expiry) begin
            counter_q <= counter_q + 4'd1;
            overrun_q <= (mask_d != 7'd0);
            if (accept) begin
              state_q      <= S_LATCH;
              step_tick_q  <= 1'b1;
              trig_valid_q <= 1'b0;
              mask_q       <= 7'd0;
              count_q      <= 24'd0;
            end else begin
              // Keep only the voice on the bus; the rest of this step is dropped.
              mask_q <= mask_q & (7'd1 << trig_voice_q);
              late_q <= 1'b1;
            end
          end else if (accept) begin
            mask_q <= mask_d;
            if (mask_d == 7'd0) begin
              state_q      <= S_WAIT;
              trig_valid_q <= 1'b0;
            end else begin
              trig_voice_q <= lowest_voice(mask_d);
            end
          end
        end
        S_WAIT: begin
          count_q <= count_q + 24'd1;
          if (expiry) begin
            counter_q   <= counter_q + 4'd1;
            state_q     <= S_LATCH;
            step_tick_q <= 1'b1;
            count_q     <= 24'd0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign counter    = counter_q;
  assign step_tick  = step_tick_q;
  assign trig_valid = trig_valid_q;
  assign trig_voice = trig_voice_q;
  assign overrun    = overrun_q;
  assign running    = running_q;

endmodule

// File: doc/step_scheduler.md
# step_scheduler

Sequencing controller for the beat sequencer's playback path. Owns step timing: divides MCLK into step periods and drives the 4-bit `counter` that indexes the seven 16-bit pattern rows. On each step it captures the hit bits, then issues per-voice trigger requests one at a time over a valid/ready handshake to the shared sample-playback engine. Sits between the pattern-row registers/front panel and the audio engine.

## Interface
- `MIN_PERIOD`, default 8: floor applied to `step_period`, in MCLK cycles; must be ≥ 8.
- `MCLK`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `poweron`  in  1  run enable; high = sequencer running.
- `row0`..`row6`  in  16 each  pattern rows; bit n = voice hit on step n (row0 bass, row1 snare, row2 clap, row3 hihat, row4 open hihat, row5 low tom, row6 high tom).
- `mute`  in  7  bit v suppresses voice v triggers.
- `step_period`  in  24  MCLK cycles per step; sampled only in LATCH.
- `trig_ready`  in  1  engine accepts presented trigger.
- `counter`  out  4  current step index.
- `step_tick`  out  1  one-cycle pulse in LATCH.
- `trig_valid`  out  1  trigger presented.
- `trig_voice`  out  3  voice number 0..6 of presented trigger.
- `overrun`  out  1  one-cycle pulse when a step expires with triggers dropped.
- `running`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LATCH, ISSUE, WAIT.
- IDLE: `counter`=0, period counter cleared. `poweron`=1 → LATCH.
- LATCH (one cycle): `step_tick`=1; `period_q` ← max(`step_period`, MIN_PERIOD); `mask` ← {row6[counter],…,row0[counter]} & ~`mute`; period counter = 0. Next: ISSUE if mask≠0, else WAIT.
- ISSUE: `trig_valid`=1, `trig_voice` = lowest set bit of `mask`. Held stable until `trig_ready`. On accept, clear that bit; if mask becomes 0 → WAIT, else present next voice on the following cycle, with no bubble.
- WAIT: idle until expiry.
- Period counter increments every cycle from LATCH. Expiry = count == `period_q`−1. On expiry, `counter` ← `counter`+1 mod 16, with 15→0 wrap, then LATCH. The step is exactly `period_q` cycles.
- Expiry while in ISSUE with pending bits:
  - Pulse `overrun`.
  - Clear all mask bits except the one presented.
  - Advance `counter`.
  - Keep presenting until accepted; then go to LATCH without waiting. A late step shortens no later step.
- Expiry on the same cycle as the last accept is not an overrun; go to LATCH.
- `poweron`=0 in any state → next cycle IDLE. `trig_valid` drops immediately, so an in-flight trigger is abandoned. `counter`=0, `mask` cleared.
- `reset` overrides everything: IDLE, all outputs 0.

## Timing
- Reset values: `counter`=0, `step_tick`=0, `trig_valid`=0, `trig_voice`=0, `overrun`=0, `running`=0.
- `poweron` sampled high at cycle t → LATCH at t+1 (`step_tick`, `counter`=0) → first `trig_valid` at t+2.
- Outputs are registered; `trig_ready` is combinationally consumed on the accept edge only.
- Row inputs are sampled only in LATCH. Edits mid-step take effect next visit to that step.
- Max triggers per step = 7. With `trig_ready` tied high, all 7 issue in cycles LATCH+1..LATCH+7, so MIN_PERIOD 8 never overruns.

## Test plan
- `step_period`=20, `row0`=16'h0001, `trig_ready`=1, `poweron` rises → `step_tick` every 20 cycles; `trig_voice`=0 pulse only when `counter`=0; `counter` wraps 15→0 after 320 cycles.
- All rows 16'hFFFF, `mute`=7'b0000100, ready=1 → per step, voices 0,1,3,4,5,6 on six consecutive cycles starting LATCH+1; voice 2 never issued.
- All rows at step 0 set, `step_period`=10, ready low for 12 cycles then high → voice 0 held stable; `overrun` pulse at cycle 9; `counter`=1 after accept; LATCH the cycle after accept; no further step-0 triggers.
- `step_period`=3 → effective period 8 cycles between `step_tick` pulses.
- `poweron` dropped while `trig_valid`=1, ready=0 → next cycle `trig_valid`=0, `counter`=0, `running`=0; re-enable restarts at step 0.
- `reset` asserted mid-ISSUE at `counter`=7 → next cycle all outputs 0, state IDLE even with `poweron`=1; LATCH occurs the cycle after `reset` deasserts.
